scmp_muldiv: RTL and testbench
==============================

Name: scmp_muldiv

Overview:
Multi-cycle multiply/divide unit that sits beside the combinational ALU in the SC/MP datapath. It consumes AC and E from the register file and returns a 16-bit result as new AC:E values for the microcode to write back. The microcode sequencer stalls on busy and uses done to resume. The single-cycle ALU handles all other operations; this block covers the MPY and DIV instructions only.

Parameters:
- MPY_ITERS, 8, shift-add iterations for multiply. Fixed; not to be overridden.
- DIV_ITERS, 16, restoring-division iterations for divide. Fixed; not to be overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  1  operation select: 0 = MPY, 1 = DIV.
- ac_i  input  8  AC operand.
- e_i  input  8  E operand.
- div_i  input  8  divisor, used for DIV only.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid in this cycle.
- ac_o  output  8  result high byte, written back to AC.
- e_o  output  8  result low byte, written back to E.
- rem_o  output  8  DIV remainder; 0 after MPY.
- dz_o  output  1  divide-by-zero flag for the last DIV; 0 after MPY.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - busy=0, done=0, ac_o=0, e_o=0, rem_o=0, dz_o=0.
  - Reset wins over any other event, including an operation in flight; the partial result is discarded and no done pulse is produced.
- States: IDLE, SETUP, ITER, FIXUP, FINISH.
- IDLE:
  - start=1 at an edge latches op, ac_i, e_i and div_i and moves to SETUP.
  - Operand inputs are ignored at every other time.
- SETUP (1 cycle):
  - MPY: record the product sign as ac_i[7]^e_i[7]; load the magnitudes |ac_i| and |e_i| (-128 gives magnitude 128, 9-bit internal).
  - DIV: if div_i=0, go to FINISH with quotient 16'hFFFF, remainder 8'h00, dz=1. Otherwise clear the partial remainder and load the 16-bit dividend {ac_i,e_i}.
  - Otherwise go to ITER and clear the iteration counter.
- ITER:
  - One iteration per cycle.
  - MPY: 8 shift-add steps.
  - DIV: 16 restoring steps, unsigned; each quotient bit is 1 when the shifted partial remainder is >= the divisor (9-bit compare).
  - When the counter reaches the last iteration, go to FIXUP.
- FIXUP (1 cycle):
  - MPY: apply two's-complement negation to the 16-bit product if the sign bit is set.
  - DIV: no change.
- FINISH:
  - Drive ac_o, e_o, rem_o, dz_o and assert done=1 for exactly this cycle, then return to IDLE.
  - Outputs hold their values until the next FINISH or reset.
- Result mapping:
  - MPY: signed 8x8 to 16-bit product. ac_o = P[15:8], e_o = P[7:0], rem_o = 0, dz_o = 0.
  - DIV: unsigned 16/8. ac_o = Q[15:8], e_o = Q[7:0], rem_o = R[7:0], dz_o = 0 unless div_i was 0.
- Latency, with start high in cycle N:
  - MPY: done in cycle N+11.
  - DIV: done in cycle N+19.
  - DIV by zero: done in cycle N+2.
- busy is 1 from cycle N+1 through the done cycle inclusive, and 0 in IDLE.
- start while busy=1 is ignored: no queuing, no operand capture, no effect on the current operation.
- start in the cycle after done is accepted normally; back-to-back operations are allowed.
- Arithmetic:
  - The product magnitude fits in 15 bits (max 128*128 = 16384), so negation never overflows 16 bits.
  - The quotient always fits in 16 bits and the remainder is always < div_i.

Test Plan:
- MPY: ac_i=07, e_i=FD (-3) -> done at N+11, ac_o=FF, e_o=EB (-21), rem_o=00, dz_o=0; busy high N+1..N+11.
- MPY: ac_i=80, e_i=80 (-128*-128) -> ac_o=40, e_o=00. MPY ac_i=80, e_i=01 -> ac_o=FF, e_o=80.
- DIV: ac_i=12, e_i=34, div_i=10 -> done at N+19, ac_o=01, e_o=23, rem_o=04, dz_o=0. DIV FFFF/FF -> ac_o=01, e_o=01, rem_o=00.
- DIV by zero: ac_i=55, e_i=AA, div_i=00 -> done at N+2, ac_o=FF, e_o=FF, rem_o=00, dz_o=1. A following MPY 02*03 clears dz_o and gives ac_o=00, e_o=06.
- start pulsed at N+3 with different operands during the MPY 07*FD case -> single done at N+11 with result FFEB; no second done.
- rst=1 at N+5 of a DIV -> next cycle busy=0, done never pulses, ac_o, e_o, rem_o all 00. A new start is accepted immediately after rst deasserts.

Source files
------------

// File: rtl/scmp_muldiv_if.sv
// Operand/result bundle between the SC/MP microcode sequencer and the multiply/divide unit.
// The sequencer drives requests through the master modport; the unit uses the slave modport.
interface scmp_muldiv_if;
  logic       start;
  logic       op;
  logic [7:0] ac_i;
  logic [7:0] e_i;
  logic [7:0] div_i;
  logic       busy;
  logic       done;
  logic [7:0] ac_o;
  logic [7:0] e_o;
  logic [7:0] rem_o;
  logic       dz_o;

  modport master (
    output start, op, ac_i, e_i, div_i,
    input  busy, done, ac_o, e_o, rem_o, dz_o
  );

  modport slave (
    input  start, op, ac_i, e_i, div_i,
    output busy, done, ac_o, e_o, rem_o, dz_o
  );
endinterface

// File: rtl/scmp_muldiv.sv
// Multi-cycle MPY (signed 8x8 shift-add) and DIV (unsigned 16/8 restoring) unit for SC/MP.
// Results land in AC:E on the single-cycle done pulse and hold until the next result or reset.
module scmp_muldiv #(
  parameter int unsigned MPY_ITERS = 8,
  parameter int unsigned DIV_ITERS = 16
) (
  input logic          clk,
  input logic          rst,
  scmp_muldiv_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StIter, StFixup, StFinish} state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [7:0]  a_q, a_d, e_q, e_d, dv_q, dv_d;
  logic        sign_q, sign_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mc_q, mc_d;
  logic [8:0]  mp_q, mp_d;
  logic [7:0]  rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  res_ac_q, res_ac_d, res_e_q, res_e_d, res_rem_q, res_rem_d;
  logic        res_dz_q, res_dz_d;

  logic [8:0]  a_sx, e_sx, a_mag, e_mag;
  logic [8:0]  div_shift;
  logic        div_ge;
  logic [3:0]  last_cnt;
  logic [15:0] fix_val;

  // 9-bit magnitudes so that -128 maps cleanly to +128.
  assign a_sx  = {a_q[7], a_q};
  assign e_sx  = {e_q[7], e_q};
  assign a_mag = a_q[7] ? (~a_sx + 9'd1) : a_sx;
  assign e_mag = e_q[7] ? (~e_sx + 9'd1) : e_sx;

  assign div_shift = {rem_q, acc_q[15]};
  assign div_ge    = div_shift >= {1'b0, dv_q};
  assign last_cnt  = op_q ? 4'(DIV_ITERS - 1) : 4'(MPY_ITERS - 1);
  assign fix_val   = (!op_q && sign_q) ? (~acc_q + 16'd1) : acc_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    e_d       = e_q;
    dv_d      = dv_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    mc_d      = mc_q;
    mp_d      = mp_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    res_ac_d  = res_ac_q;
    res_e_d   = res_e_q;
    res_rem_d = res_rem_q;
    res_dz_d  = res_dz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.ac_i;
          e_d     = bus.e_i;
          dv_d    = bus.div_i;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d = '0;
        if (op_q) begin
          if (dv_q == 8'h00) begin
            res_ac_d  = 8'hFF;
            res_e_d   = 8'hFF;
            res_rem_d = 8'h00;
            res_dz_d  = 1'b1;
            state_d   = StFinish;
          end else begin
            rem_d   = '0;
            acc_d   = {a_q, e_q};
            state_d = StIter;
          end
        end else begin
          sign_d  = a_q[7] ^ e_q[7];
          mc_d    = {7'd0, a_mag};
          mp_d    = e_mag;
          acc_d   = '0;
          state_d = StIter;
        end
      end
      StIter: begin
        if (op_q) begin
          // acc shifts the dividend out the top and the quotient bits in at the bottom.
          rem_d = div_ge ? 8'(div_shift - {1'b0, dv_q}) : div_shift[7:0];
          acc_d = {acc_q[14:0], div_ge};
        end else begin
          if (mp_q[0]) acc_d = acc_q + mc_q;
          mc_d = {mc_q[14:0], 1'b0};
          mp_d = {1'b0, mp_q[8:1]};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == last_cnt) state_d = StFixup;
      end
      StFixup: begin
        acc_d     = fix_val;
        res_ac_d  = fix_val[15:8];
        res_e_d   = fix_val[7:0];
        res_rem_d = op_q ? rem_q : 8'h00;
        res_dz_d  = 1'b0;
        state_d   = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= 1'b0;
      a_q       <= '0;
      e_q       <= '0;
      dv_q      <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      mc_q      <= '0;
      mp_q      <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      res_ac_q  <= '0;
      res_e_q   <= '0;
      res_rem_q <= '0;
      res_dz_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      e_q       <= e_d;
      dv_q      <= dv_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      mc_q      <= mc_d;
      mp_q      <= mp_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      res_ac_q  <= res_ac_d;
      res_e_q   <= res_e_d;
      res_rem_q <= res_rem_d;
      res_dz_q  <= res_dz_d;
    end
  end

  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = (state_q == StFinish);
  assign bus.ac_o  = res_ac_q;
  assign bus.e_o   = res_e_q;
  assign bus.rem_o = res_rem_q;
  assign bus.dz_o  = res_dz_q;

endmodule

// File: tb/tb_scmp_muldiv.sv
// Bench for scmp_muldiv: directed vector table, random ops against an arithmetic model,
// and hand-written sequences for ignored start and mid-operation reset.
module tb_scmp_muldiv;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] last_ac, last_e, last_rem;
  logic       last_dz;

  scmp_muldiv_if bus ();

  scmp_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] e;
    logic [7:0] d;
    logic [7:0] xac;
    logic [7:0] xe;
    logic [7:0] xrem;
    logic       xdz;
    int         lat;
    int         glitch;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain signed multiply / unsigned divide on the operand values.
  task automatic model(input logic op, input logic [7:0] a, input logic [7:0] e,
                       input logic [7:0] d, output logic [7:0] xac, output logic [7:0] xe,
                       output logic [7:0] xrem, output logic xdz, output int lat);
    int          p;
    int unsigned n, q, r;
    if (!op) begin
      p    = int'($signed(a)) * int'($signed(e));
      xac  = p[15:8];
      xe   = p[7:0];
      xrem = 8'h00;
      xdz  = 1'b0;
      lat  = 11;
    end else if (d == 8'h00) begin
      xac  = 8'hFF;
      xe   = 8'hFF;
      xrem = 8'h00;
      xdz  = 1'b1;
      lat  = 2;
    end else begin
      n    = {16'd0, a, e};
      q    = n / {24'd0, d};
      r    = n % {24'd0, d};
      xac  = q[15:8];
      xe   = q[7:0];
      xrem = r[7:0];
      xdz  = 1'b0;
      lat  = 19;
    end
  endtask

  // Start one operation in the next cycle, optionally re-pulse start while busy at cycle N+glitch.
  task automatic run_op(input string nm, input logic op, input logic [7:0] a, input logic [7:0] e,
                        input logic [7:0] d, input logic [7:0] xac, input logic [7:0] xe,
                        input logic [7:0] xrem, input logic xdz, input int lat,
                        input int glitch);
    int k;
    bit got;
    @(negedge clk);
    chk({nm, " idle busy"}, {31'd0, bus.busy}, 32'd0);
    chk({nm, " idle done"}, {31'd0, bus.done}, 32'd0);
    chk({nm, " hold result"}, {bus.dz_o, bus.ac_o, bus.e_o, bus.rem_o},
        {last_dz, last_ac, last_e, last_rem});
    bus.start = 1'b1;
    bus.op    = op;
    bus.ac_i  = a;
    bus.e_i   = e;
    bus.div_i = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.ac_i  = 8'($urandom);
    bus.e_i   = 8'($urandom);
    bus.div_i = 8'($urandom);
    k   = 1;
    got = 1'b0;
    while (!got && k <= 40) begin
      @(negedge clk);
      chk({nm, " busy"}, {31'd0, bus.busy}, 32'd1);
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (k == glitch) begin
          bus.start = 1'b1;
          bus.op    = 1'($urandom);
          bus.ac_i  = 8'($urandom);
          bus.e_i   = 8'($urandom);
          bus.div_i = 8'($urandom);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k++;
      end
    end
    chk({nm, " latency"}, 32'(k), 32'(lat));
    chk({nm, " ac_o"}, {24'd0, bus.ac_o}, {24'd0, xac});
    chk({nm, " e_o"}, {24'd0, bus.e_o}, {24'd0, xe});
    chk({nm, " rem_o"}, {24'd0, bus.rem_o}, {24'd0, xrem});
    chk({nm, " dz_o"}, {31'd0, bus.dz_o}, {31'd0, xdz});
    last_ac  = xac;
    last_e   = xe;
    last_rem = xrem;
    last_dz  = xdz;
  endtask

  vec_t vecs[8];

  initial begin
    logic [7:0] xac, xe, xrem, ra, re, rd;
    logic       xdz, rop;
    int         lat, gl;

    checks    = 0;
    failures  = 0;
    last_ac   = 8'h00;
    last_e    = 8'h00;
    last_rem  = 8'h00;
    last_dz   = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.ac_i  = 8'h00;
    bus.e_i   = 8'h00;
    bus.div_i = 8'h00;

    //            op    a      e      d      xac    xe     xrem   xdz   lat glitch
    vecs[0] = '{1'b0, 8'h07, 8'hFD, 8'h00, 8'hFF, 8'hEB, 8'h00, 1'b0, 11, 0};
    vecs[1] = '{1'b0, 8'h07, 8'hFD, 8'h33, 8'hFF, 8'hEB, 8'h00, 1'b0, 11, 3};
    vecs[2] = '{1'b0, 8'h80, 8'h80, 8'h00, 8'h40, 8'h00, 8'h00, 1'b0, 11, 0};
    vecs[3] = '{1'b0, 8'h80, 8'h01, 8'h00, 8'hFF, 8'h80, 8'h00, 1'b0, 11, 0};
    vecs[4] = '{1'b1, 8'h12, 8'h34, 8'h10, 8'h01, 8'h23, 8'h04, 1'b0, 19, 0};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'h00, 1'b0, 19, 5};
    vecs[6] = '{1'b1, 8'h55, 8'hAA, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b1, 2, 0};
    vecs[7] = '{1'b0, 8'h02, 8'h03, 8'h00, 8'h00, 8'h06, 8'h00, 1'b0, 11, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset outputs", {bus.dz_o, bus.ac_o, bus.e_o, bus.rem_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].e, vecs[i].d, vecs[i].xac,
             vecs[i].xe, vecs[i].xrem, vecs[i].xdz, vecs[i].lat, vecs[i].glitch);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom);
      ra  = 8'($urandom);
      re  = 8'($urandom);
      rd  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      gl  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 8));
      model(rop, ra, re, rd, xac, xe, xrem, xdz, lat);
      run_op($sformatf("rnd%0d", i), rop, ra, re, rd, xac, xe, xrem, xdz, lat, gl);
    end

    // Reset during a DIV: nothing completes and the held results clear.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.ac_i  = 8'h12;
    bus.e_i   = 8'h34;
    bus.div_i = 8'h10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_ac  = 8'h00;
    last_e   = 8'h00;
    last_rem = 8'h00;
    last_dz  = 1'b0;
    model(1'b1, 8'hA5, 8'h3C, 8'h07, xac, xe, xrem, xdz, lat);
    run_op("after rst", 1'b1, 8'hA5, 8'h3C, 8'h07, xac, xe, xrem, xdz, lat, 0);
    model(1'b0, 8'hF6, 8'h0C, 8'h00, xac, xe, xrem, xdz, lat);
    run_op("after rst mpy", 1'b0, 8'hF6, 8'h0C, 8'h00, xac, xe, xrem, xdz, lat, 0);

    @(negedge clk);
    chk("final idle busy", {31'd0, bus.busy}, 32'd0);
    chk("final no done", {31'd0, bus.done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
